// File: rtl/fifo_tree_pkg.sv
// Shared types and constants for the SAT clause/literal FIFO tree nodes.
// Holds the default word width, skid depth and the tagged-word layout.
package fifo_tree_pkg;

    localparam int FIFO_DATA_WIDTH = 36;
    localparam int SKID_DEPTH      = 2;
    localparam int MAX_SRC_WIDTH   = 4;

    // Tagged word at the default tree configuration (up to 16 sources).
    typedef struct packed {
        logic [MAX_SRC_WIDTH-1:0]   src;
        logic [FIFO_DATA_WIDTH-1:0] data;
    } tagged_word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request found searching upward
// from ptr+1 with wrap; returns one-hot grant, its index and any_grant.
module rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 any_grant
);

    int cand;

    always_comb begin
        // NOTE: every output gets a default before the search so no latch is inferred.
        grant     = '0;
        idx       = '0;
        any_grant = 1'b0;
        cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!any_grant && req[cand]) begin
                any_grant   = 1'b1;
                grant[cand] = 1'b1;
                idx         = IDX_WIDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Round-robin reader for NUM_SRC FIFO_Buffers feeding a 2-entry skid buffer
// and a tagged valid/ready stream. Optional counters: FIFO_DRAIN_STATS_EN.
module fifo_drain_arbiter
    import fifo_tree_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int NUM_SRC    = 4,
    parameter int SRC_WIDTH  = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] fifo_data_i,
    input  logic [NUM_SRC-1:0]            fifo_empty_i,
    output logic [NUM_SRC-1:0]            fifo_rden_o,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic [SRC_WIDTH-1:0]          src_o,
    output logic                          valid_o,
    input  logic                          ready_i
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [31:0]                   pop_count_o,
    output logic [31:0]                   stall_count_o
`endif
);

    typedef struct packed {
        logic [SRC_WIDTH-1:0]  src;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                 skid [SKID_DEPTH];
    logic                   head;
    logic                   tail;
    logic [1:0]             count;
    logic                   inflight;
    logic [SRC_WIDTH-1:0]   inflight_src;
    logic [SRC_WIDTH-1:0]   ptr;

    logic [NUM_SRC-1:0]     req;
    logic [NUM_SRC-1:0]     grant;
    logic [SRC_WIDTH-1:0]   grant_idx;
    logic                   any_req;
    logic                   pop;
    logic                   issue;
    logic [2:0]             level;
    logic [DATA_WIDTH-1:0]  inflight_data;

    assign req = ~fifo_empty_i;

    rr_arbiter #(
        .NUM_REQ   (NUM_SRC),
        .IDX_WIDTH (SRC_WIDTH)
    ) u_arb (
        .req       (req),
        .ptr       (ptr),
        .grant     (grant),
        .idx       (grant_idx),
        .any_grant (any_req)
    );

    assign valid_o = (count != 2'd0);
    assign data_o  = skid[head].data;
    assign src_o   = skid[head].src;
    assign pop     = valid_o & ready_i;

    // Occupancy after this cycle's pop, counting the word still in flight.
    assign level = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

    // Gating with reset_n keeps the FIFOs from being popped while reset is held.
    assign issue       = any_req && (level < 3'(SKID_DEPTH)) && reset_n;
    assign fifo_rden_o = issue ? grant : '0;

    always_comb begin
        inflight_data = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (SRC_WIDTH'(s) == inflight_src) begin
                inflight_data = fifo_data_i[s*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr          <= SRC_WIDTH'(NUM_SRC - 1);
            inflight     <= 1'b0;
            inflight_src <= '0;
            head         <= 1'b0;
            tail         <= 1'b0;
            count        <= 2'd0;
            // NOTE: skid entries are reset so data_o/src_o read zero after reset.
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values.
            inflight <= issue;
            if (issue) begin
                ptr          <= grant_idx;
                inflight_src <= grant_idx;
            end
            if (inflight) begin
                skid[tail] <= '{src: inflight_src, data: inflight_data};
                tail       <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

`ifdef FIFO_DRAIN_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pop_count_o   <= '0;
            stall_count_o <= '0;
        end else begin
            if (pop) begin
                pop_count_o <= pop_count_o + 32'd1;
            end
            if (valid_o && !ready_i) begin
                stall_count_o <= stall_count_o + 32'd1;
            end
        end
    end
`endif

endmodule
